console_arbiter: RTL and testbench
==================================

// Module: console_arbiter
// PURPOSE
// Round-robin scheduler that drains N_CH per-console fifo instances into one shared
// byte sink (UART TX). Sits between the console fifos and the TX serializer.
// Emits a channel tag byte whenever the source channel changes. Holds the grant until
// end of line so console lines never interleave. Owns every fifo advance_read_ptr strobe.
// PARAMETERS
// N_CH          4      number of console fifos (2..16)
// WIDTH         8      byte width, equal to the fifo WIDTH
// MAX_BURST     64     maximum data bytes per grant before a forced release
// HOLD_TIMEOUT  255    idle cycles a granted, empty channel is held before release
// TAG_BASE      8'hF0  tag byte = TAG_BASE + channel index
// EOL           8'h0A  byte that ends a line and releases the grant
// PORTS
// clk          in   1            system clock, all logic on posedge
// rst_n        in   1            asynchronous active-low reset
// ch_empty     in   N_CH         fifo empty flags, bit i = channel i
// ch_data      in   N_CH*WIDTH   fifo data_out buses, channel i at [i*WIDTH +: WIDTH]
// ch_advance   out  N_CH         one-hot advance_read_ptr strobes to the fifos
// tx_data      out  WIDTH        byte offered to the sink
// tx_valid     out  1            tx_data is valid
// tx_ready     in   1            sink accepts the byte on the cycle where valid && ready
// busy         out  1            a grant is held (state != IDLE)
// cur_ch       out  clog2(N_CH)  granted channel; holds the last grant when idle
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, last_grant=N_CH-1, tag_valid=0, counters=0.
//   Outputs: tx_valid=0, tx_data=0, ch_advance=0, busy=0, cur_ch=0.
//   A reset mid-transfer drops tx_valid immediately. No advance is issued.
// - All outputs decode combinationally from registered state, grant and counters.
// - Fifo timing: data_out is registered. After an advance edge, empty is valid 1 cycle
//   later and data_out is valid 2 cycles later. The SETTLE state exists for this.
// - IDLE: search from last_grant+1 with wrap for the first channel where ch_empty=0.
//   If none is found, stay in IDLE. If one is found: grant=idx, burst=0, hold=0.
//   Go to TAG if !tag_valid or idx!=last_tag_ch, else go to SETTLE.
// - TAG: tx_valid=1, tx_data=TAG_BASE+grant. On tx_ready: last_tag_ch=grant,
//   tag_valid=1, go to SETTLE. Tag bytes do not count toward burst.
// - SETTLE: 2 cycles (cnt 1,0). Then:
//   - ch_empty[grant]=0: go to SEND.
//   - ch_empty[grant]=1: go to HOLD.
// - SEND: tx_valid=1, tx_data=ch_data[grant]. While ready=0, tx_data/valid stay stable
//   and no advance is issued. On tx_ready, in the same cycle:
//   ch_advance[grant]=1 (single-cycle pulse), burst=burst+1.
//   - Byte == EOL, or burst+1 == MAX_BURST: go to IDLE, last_grant=grant.
//   - Otherwise: go to SETTLE.
// - HOLD: hold increments each cycle. Then:
//   - ch_empty[grant]=0: go to SEND, hold=0.
//   - hold == HOLD_TIMEOUT: go to IDLE, last_grant=grant.
// - Other channels are never advanced while a grant is held; requests only queue.
// - Simultaneous requests are served in round-robin order after last_grant. For example,
//   with N_CH=4, last_grant=1, and channels 0 and 3 pending, channel 3 wins.
// - Tx never holds valid=1 in IDLE/SETTLE/HOLD. Exactly one advance per accepted data byte.
// - The full flag on the write side is not observed. Overflow policy belongs to the writers.
// - Counters saturate-free: burst width is clog2(MAX_BURST+1), hold width is
//   clog2(HOLD_TIMEOUT+1).
// TESTING
// 1. Reset, ch0 holds "hi\n", tx_ready=1.
//    -> tx stream F0,'h','i',0A; exactly 3 ch_advance[0] pulses; busy=0 afterwards.
// 2. ch1 "a\n" and ch2 "b\n" both pending from IDLE, last_grant=3.
//    -> F1,'a',0A,F2,'b',0A. No tag is repeated for the same channel on its next grant.
// 3. tx_ready held 0 for 10 cycles mid-SEND.
//    -> tx_data/tx_valid stable, ch_advance=0 throughout; one advance when ready rises.
// 4. ch0 sends "ab" with no EOL, then goes empty.
//    -> HOLD for 255 cycles, then IDLE. A pending ch1 is tagged F1 next.
//    If ch0 refills at hold=100, 'c' is sent with no re-tag.
// 5. MAX_BURST=4, ch0 holds 10 bytes with no EOL, ch1 pending.
//    -> 4 ch0 bytes, F1 + ch1 data, then F0 + remaining ch0 bytes.
// 6. rst_n pulsed low mid-SEND with tx_ready=0.
//    -> tx_valid drops asynchronously, no advance; after release the first byte is re-tagged.

Source files
------------

// File: rtl/console_arbiter_if.sv
// Console arbiter bus: fifo read side plus tx byte stream.
// master = arbiter, slave = fifos/sink side.
interface console_arbiter_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0]       ch_empty;
  logic [N_CH*WIDTH-1:0] ch_data;
  logic [N_CH-1:0]       ch_advance;
  logic [WIDTH-1:0]      tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic [CW-1:0]         cur_ch;

  modport master (
    input  ch_empty, ch_data, tx_ready,
    output ch_advance, tx_data, tx_valid, busy, cur_ch
  );

  modport slave (
    output ch_empty, ch_data, tx_ready,
    input  ch_advance, tx_data, tx_valid, busy, cur_ch
  );
endinterface

// File: rtl/console_arbiter.sv
// Round-robin line arbiter draining console fifos into one tx sink.
// Tags channel switches and holds the grant until end of line.
module console_arbiter #(
  parameter int              N_CH         = 4,
  parameter int              WIDTH        = 8,
  parameter int              MAX_BURST    = 64,
  parameter int              HOLD_TIMEOUT = 255,
  parameter logic [WIDTH-1:0] TAG_BASE    = 8'hF0,
  parameter logic [WIDTH-1:0] EOL         = 8'h0A
) (
  input logic             clk,
  input logic             rst_n,
  console_arbiter_if.master bus
);
  localparam int CW = $clog2(N_CH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, TAG, SETTLE, SEND, HOLD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] grant, grant_n;
  logic [CW-1:0] last_grant, last_grant_n;
  logic [CW-1:0] last_tag, last_tag_n;
  logic          tag_valid, tag_valid_n;
  logic [BW-1:0] burst, burst_n;
  logic [HW-1:0] hold, hold_n;
  logic          cnt, cnt_n;

  logic             found;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] cur_byte;
  logic [BW-1:0]    burst_inc;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic [N_CH-1:0]  advance;

  assign cur_byte  = bus.ch_data[int'(grant)*WIDTH +: WIDTH];
  assign burst_inc = burst + BW'(1);

  // first non-empty channel after last_grant, wrapping
  always_comb begin
    found = 1'b0;
    idx   = last_grant;
    for (int k = 1; k <= N_CH; k++) begin
      if (!found && !bus.ch_empty[(int'(last_grant) + k) % N_CH]) begin
        found = 1'b1;
        idx   = CW'((int'(last_grant) + k) % N_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CW'(N_CH - 1);
      last_tag   <= '0;
      tag_valid  <= 1'b0;
      burst      <= '0;
      hold       <= '0;
      cnt        <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      last_tag   <= last_tag_n;
      tag_valid  <= tag_valid_n;
      burst      <= burst_n;
      hold       <= hold_n;
      cnt        <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    last_tag_n   = last_tag;
    tag_valid_n  = tag_valid;
    burst_n      = burst;
    hold_n       = hold;
    cnt_n        = cnt;
    tx_valid     = 1'b0;
    tx_data      = '0;
    advance      = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = idx;
          burst_n = '0;
          hold_n  = '0;
          cnt_n   = 1'b1;
          if (!tag_valid || idx != last_tag) state_n = TAG;
          else                               state_n = SETTLE;
        end
      end
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = TAG_BASE + WIDTH'(grant);
        if (bus.tx_ready) begin
          last_tag_n  = grant;
          tag_valid_n = 1'b1;
          cnt_n       = 1'b1;
          state_n     = SETTLE;
        end
      end
      // fifo flags/data lag the advance strobe
      SETTLE: begin
        if (cnt)                       cnt_n   = 1'b0;
        else if (!bus.ch_empty[grant]) state_n = SEND;
        else                           state_n = HOLD;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (bus.tx_ready) begin
          advance[grant] = 1'b1;
          burst_n        = burst_inc;
          if (cur_byte == EOL || burst_inc == BW'(MAX_BURST)) begin
            state_n      = IDLE;
            last_grant_n = grant;
          end else begin
            cnt_n   = 1'b1;
            state_n = SETTLE;
          end
        end
      end
      HOLD: begin
        if (!bus.ch_empty[grant]) begin
          state_n = SEND;
          hold_n  = '0;
        end else if (hold == HW'(HOLD_TIMEOUT)) begin
          state_n      = IDLE;
          last_grant_n = grant;
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.tx_valid   = tx_valid;
  assign bus.tx_data    = tx_data;
  assign bus.ch_advance = advance;
  assign bus.busy       = (state != IDLE);
  assign bus.cur_ch     = grant;
endmodule

// File: tb/tb_console_arbiter.sv
// Bench for console_arbiter: fifo models, line-level stream model,
// directed scenarios plus randomized multi-channel phases.
module tb_console_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int HT = 255;
  localparam logic [7:0] TAGB = 8'hF0;
  localparam logic [7:0] EOL  = 8'h0A;

  typedef struct {
    logic [7:0] b;
    int         ch;
    bit         tag;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  console_arbiter_if #(.N_CH(N), .WIDTH(W)) bus ();

  console_arbiter #(
    .N_CH(N), .WIDTH(W), .MAX_BURST(MB), .HOLD_TIMEOUT(HT),
    .TAG_BASE(TAGB), .EOL(EOL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int mode = 0;
  int cyc = 0;
  int adv_total = 0;
  int data_total = 0;
  int m_lg, m_tv, m_lt;
  bit pend = 1'b0;
  logic [7:0] pend_d;
  ev_t e;
  ev_t exp_q[$];
  logic [7:0] fq[N][$];
  logic [7:0] nxt[N];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp_v);
    end
  endtask

  task automatic pin(input string nm, input int i, input logic [7:0] v);
    chk(nm, (i < exp_q.size()) ? {24'd0, exp_q[i].b} : 32'hFFFF, {24'd0, v});
  endtask

  // fifo: empty follows the pointer at the edge, data one cycle later
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.ch_advance[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      bus.ch_empty[i] <= (fq[i].size() == 0);
      bus.ch_data[i*W +: W] <= nxt[i];
      nxt[i] <= (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  end

  always @(posedge clk) begin
    #1;
    case (mode)
      0: bus.tx_ready = ($urandom_range(0, 9) < 7);
      1: bus.tx_ready = bus.tx_valid && (bus.tx_data[7:4] == 4'hF);
      default: bus.tx_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend)
        chk("stall_stable", {23'd0, bus.tx_valid, bus.tx_data},
            {23'd0, 1'b1, pend_d});
      if (bus.tx_valid) chk("busy_with_valid", {31'd0, bus.busy}, 1);
      for (int i = 0; i < N; i++) if (bus.ch_advance[i]) adv_total++;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {24'd0, bus.tx_data}, {24'd0, e.b});
          chk("cur_ch", {30'd0, bus.cur_ch}, e.ch);
          chk("advance", {28'd0, bus.ch_advance}, e.tag ? 0 : (1 << e.ch));
        end
      end else begin
        chk("stray_advance", {28'd0, bus.ch_advance}, 0);
      end
      pend   = bus.tx_valid && !bus.tx_ready;
      pend_d = bus.tx_data;
    end
  end

  // line-level reference: round robin, tag on channel change,
  // release on EOL, burst limit or running dry (timeout)
  function automatic void model_drain(input int xch, input string xs);
    logic [7:0] q[N][$];
    int c, burst, j;
    logic [7:0] b;
    for (int i = 0; i < N; i++) q[i] = fq[i];
    if (xch >= 0) for (int i = 0; i < xs.len(); i++) q[xch].push_back(xs[i]);
    while (1) begin
      c = -1;
      for (int k = 1; k <= N; k++) begin
        j = (m_lg + k) % N;
        if (c < 0 && q[j].size() > 0) c = j;
      end
      if (c < 0) break;
      if (!m_tv || m_lt != c) exp_q.push_back('{TAGB + 8'(c), c, 1'b1});
      m_tv = 1;
      m_lt = c;
      burst = 0;
      while (q[c].size() > 0) begin
        b = q[c].pop_front();
        exp_q.push_back('{b, c, 1'b0});
        data_total++;
        burst++;
        if (b == EOL || burst == MB) break;
      end
      m_lg = c;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int ch, input string s);
    for (int i = 0; i < s.len(); i++) fq[ch].push_back(s[i]);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 6000) begin
      tick();
      n++;
    end
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_busy"}, {31'd0, bus.busy}, 0);
    chk({nm, "_valid"}, {31'd0, bus.tx_valid}, 0);
  endtask

  task automatic wait_byte(input string nm, input logic [7:0] v);
    int n = 0;
    while (!(bus.tx_valid && bus.tx_data == v) && n < 80) begin
      tick();
      n++;
    end
    chk(nm, {24'd0, bus.tx_data}, {24'd0, v});
  endtask

  initial begin
    int t0, gap, adv0, pushed, len;
    m_lg = N - 1;
    m_tv = 0;
    m_lt = 0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, bus.tx_valid}, 0);
    chk("rst_data", {24'd0, bus.tx_data}, 0);
    chk("rst_adv", {28'd0, bus.ch_advance}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_cur_ch", {30'd0, bus.cur_ch}, 0);
    rst_n = 1'b1;
    tick();

    mode = 2;
    load(0, "hi\n");
    model_drain(-1, "");
    chk("t1_len", exp_q.size(), 4);
    pin("t1_b0", 0, 8'hF0);
    pin("t1_b1", 1, 8'h68);
    pin("t1_b2", 2, 8'h69);
    pin("t1_b3", 3, 8'h0A);
    adv0 = adv_total;
    wait_idle("t1");
    chk("t1_adv", adv_total - adv0, 3);

    load(1, "a\n");
    load(2, "b\n");
    model_drain(-1, "");
    pin("t2_b0", 0, 8'hF1);
    pin("t2_b1", 1, 8'h61);
    pin("t2_b3", 3, 8'hF2);
    pin("t2_b5", 5, 8'h0A);
    wait_idle("t2");
    load(2, "d\n");
    model_drain(-1, "");
    pin("t2_notag", 0, 8'h64);
    wait_idle("t2b");

    mode = 1;
    load(3, "pq\n");
    model_drain(-1, "");
    wait_byte("t3_wait", 8'h70);
    adv0 = adv_total;
    repeat (10) tick();
    chk("t3_stall_adv", adv_total - adv0, 0);
    mode = 2;
    wait_idle("t3");
    chk("t3_adv", adv_total - adv0, 3);

    load(0, "ab");
    load(1, "z\n");
    model_drain(-1, "");
    pin("t4_tag0", 0, 8'hF0);
    pin("t4_tag1", 3, 8'hF1);
    t0 = 0;
    while (exp_q.size() > 3 && t0 < 60) begin tick(); t0++; end
    t0 = cyc;
    gap = 0;
    while (!bus.tx_valid && gap < 400) begin tick(); gap++; end
    gap = cyc - t0;
    vectors++;
    if (gap < HT + 1 || gap > HT + 9) begin
      errs++;
      $display("FAIL hold_gap: got %0d cycles, expected %0d..%0d",
               gap, HT + 1, HT + 9);
    end
    wait_idle("t4");

    load(0, "ab");
    model_drain(0, "c\n");
    pin("t4b_tag", 0, 8'hF0);
    pin("t4b_c", 3, 8'h63);
    t0 = 0;
    while (exp_q.size() > 2 && t0 < 60) begin tick(); t0++; end
    repeat (100) tick();
    chk("t4b_held", {31'd0, bus.busy}, 1);
    load(0, "c\n");
    wait_idle("t4b");

    load(1, "klmnopqrst");
    load(2, "u\n");
    model_drain(-1, "");
    chk("t5_len", exp_q.size(), 15);
    pin("t5_tag1", 0, 8'hF1);
    pin("t5_tag2", 5, 8'hF2);
    pin("t5_retag", 8, 8'hF1);
    wait_idle("t5");

    mode = 1;
    load(2, "xyz\n");
    model_drain(-1, "");
    wait_byte("t6_wait", 8'h78);
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, bus.tx_valid}, 0);
    chk("t6_adv", {28'd0, bus.ch_advance}, 0);
    chk("t6_busy", {31'd0, bus.busy}, 0);
    chk("t6_cur_ch", {30'd0, bus.cur_ch}, 0);
    chk("t6_fifo", fq[2].size(), 4);
    tick();
    tick();
    for (int i = 0; i < exp_q.size(); i++) if (!exp_q[i].tag) data_total--;
    exp_q.delete();
    m_lg = N - 1;
    m_tv = 0;
    m_lt = 0;
    model_drain(-1, "");
    pin("t6_retag", 0, 8'hF2);
    mode = 2;
    rst_n = 1'b1;
    wait_idle("t6");

    for (int p = 0; p < 25; p++) begin
      mode = 0;
      pushed = 0;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) < 6) begin
          len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++)
            fq[c].push_back(8'($urandom_range(32, 126)));
          if ($urandom_range(0, 3) != 0) fq[c].push_back(EOL);
          pushed++;
        end
      end
      if (pushed == 0) load($urandom_range(0, N - 1), "r\n");
      model_drain(-1, "");
      wait_idle("rnd");
    end

    chk("advance_total", adv_total, data_total);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
